core_memory: RTL and testbench

- Word-addressed main-memory unit that consumes the one-cycle `mem_read_pulse` / `mem_write_pulse` strobes from the pulse/timing sequencer.
- Performs the access on an internal register array and returns a one-cycle `mem_reply` when the access completes.
- Emulates core-store timing: a fixed access phase, then for reads a restore (recovery) phase during which the unit stays busy.
- Also provides a side port for loading and inspecting memory while idle.

---
 rtl/core_memory.sv | 142 ++++++++++++++
 tb/tb_core_memory.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/core_memory.sv
// Word-addressed core-store emulation: strobe-driven accesses with a fixed access
// phase, a post-read restore phase, and an idle-only side port for load/inspect.
module core_memory #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 31,
    parameter int ACCESS_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_pulse,
    input  logic              mem_write_pulse,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_reply,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              mem_error,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RCV_LOAD = CNT_W'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        REPLY,
        RECOVER
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               is_read;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic accept, err_set, commit_wr, load_rd, dbg_wr, free_edge;
    logic any_strobe, one_strobe;

    assign any_strobe = mem_read_pulse | mem_write_pulse;
    assign one_strobe = mem_read_pulse ^ mem_write_pulse;
    assign mem_reply  = (state == REPLY);
    assign mem_busy   = (state != IDLE);
    assign dbg_rdata  = mem[dbg_addr];

    // free_edge marks the edge at which the unit returns to (or sits in) IDLE;
    // a strobe there is accepted back-to-back so throughput is not lost.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        accept    = 1'b0;
        err_set   = 1'b0;
        commit_wr = 1'b0;
        load_rd   = 1'b0;
        dbg_wr    = 1'b0;
        free_edge = 1'b0;

        case (state)
            IDLE: free_edge = 1'b1;
            ACCESS: begin
                if (cnt == '0) begin
                    state_n   = REPLY;
                    commit_wr = ~is_read;
                    load_rd   = is_read;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            REPLY: begin
                if (is_read && (RECOVER_CYCLES > 0)) begin
                    state_n = RECOVER;
                    cnt_n   = RCV_LOAD;
                end else begin
                    state_n   = IDLE;
                    free_edge = 1'b1;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_n   = IDLE;
                    free_edge = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (any_strobe) begin
            if (free_edge && one_strobe) begin
                accept  = 1'b1;
                state_n = ACCESS;
                cnt_n   = ACC_LOAD;
            end else begin
                err_set = 1'b1;
            end
        end else if (dbg_we && (state == IDLE)) begin
            dbg_wr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_error <= 1'b0;
            mem_rdata <= '0;
            is_read   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (err_set) mem_error <= 1'b1;
            if (accept) begin
                is_read <= mem_read_pulse;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (load_rd) mem_rdata <= mem[addr_q];
        end
    end

    // The commit is deliberately not gated by reset: a write reaching its
    // commit edge lands even if reset arrives at that same edge.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[addr_q] <= wdata_q;
        end else if (dbg_wr && !reset) begin
            mem[dbg_addr] <= dbg_wdata;
        end
    end

endmodule

// File: tb/tb_core_memory.sv
// Randomized plus directed bench for core_memory, checked every cycle against a
// timeline model (acceptance edge, commit edge, busy-release edge).
module tb_core_memory;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 31;
    localparam int A      = 2;
    localparam int R      = 1;
    localparam int NADDR  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              mem_read_pulse = 1'b0;
    logic              mem_write_pulse = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic              mem_reply;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busy;
    logic              mem_error;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;

    core_memory #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(A), .RECOVER_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_read_pulse(mem_read_pulse), .mem_write_pulse(mem_write_pulse),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_reply(mem_reply), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy), .mem_error(mem_error),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: access timeline expressed as edge numbers.
    int                edge_n = 0;
    int                busy_end = 0;
    int                commit_edge = -100;
    int                reply_edge = -100;
    logic              pend_valid = 1'b0;
    logic              pend_read = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [DATA_W-1:0] pend_data = '0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              m_err = 1'b0;
    logic [DATA_W-1:0] ref_mem [NADDR];
    logic              known [NADDR];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rp, input logic wp,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                 input logic dwe, input logic [ADDR_W-1:0] daddr,
                                 input logic [DATA_W-1:0] dwdata, input logic rst);
        mem_read_pulse  = rp;
        mem_write_pulse = wp;
        mem_addr        = addr;
        mem_wdata       = wdata;
        dbg_we          = dwe;
        dbg_addr        = daddr;
        dbg_wdata       = dwdata;
        reset           = rst;
        @(posedge clk);
        edge_n++;

        if (pend_valid && edge_n == commit_edge) begin
            if (pend_read) m_rdata = ref_mem[pend_addr];
            else begin
                ref_mem[pend_addr] = pend_data;
                known[pend_addr]   = 1'b1;
            end
            pend_valid = 1'b0;
        end

        if (rst) begin
            busy_end   = edge_n;
            reply_edge = -100;
            m_err      = 1'b0;
            m_rdata    = '0;
            pend_valid = 1'b0;
        end else if (rp || wp) begin
            if (edge_n >= busy_end && !(rp && wp)) begin
                pend_valid  = 1'b1;
                pend_read   = rp;
                pend_addr   = addr;
                pend_data   = wdata;
                commit_edge = edge_n + A;
                reply_edge  = edge_n + A;
                busy_end    = edge_n + A + 1 + (rp ? R : 0);
            end else begin
                m_err = 1'b1;
            end
        end else if (dwe && edge_n > busy_end) begin
            ref_mem[daddr] = dwdata;
            known[daddr]   = 1'b1;
        end

        #1;
        checkOutput("reply", 32'(mem_reply), 32'(edge_n == reply_edge));
        checkOutput("busy",  32'(mem_busy),  32'(edge_n < busy_end));
        checkOutput("error", 32'(mem_error), 32'(m_err));
        checkOutput("rdata", 32'(mem_rdata), 32'(m_rdata));
        if (known[daddr]) checkOutput("dbg_rdata", 32'(dbg_rdata), 32'(ref_mem[daddr]));
    endtask

    task automatic idleCycles(input int n, input logic [ADDR_W-1:0] daddr);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, '0, 0, daddr, '0, 0);
    endtask

    int r;
    logic rp, wp, dwe, rst;

    initial begin
        for (int i = 0; i < NADDR; i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = '0;
        end

        applyStimulus(0, 0, '0, '0, 0, '0, '0, 1);
        applyStimulus(0, 0, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < NADDR; i++)
            applyStimulus(0, 0, '0, '0, 1, ADDR_W'(i), DATA_W'($urandom), 0);

        // Write then read of address 5, with a back-to-back read at the release edge.
        applyStimulus(0, 1, 11'd5, 31'h1234567, 0, 11'd5, '0, 0);
        idleCycles(3, 11'd5);
        applyStimulus(1, 0, 11'd5, '0, 0, 11'd5, '0, 0);
        idleCycles(3, 11'd5);
        applyStimulus(1, 0, 11'd5, '0, 0, 11'd5, '0, 0);
        idleCycles(5, 11'd5);

        applyStimulus(0, 0, '0, '0, 0, 11'd5, '0, 1);
        applyStimulus(1, 1, 11'd5, 31'h0, 0, 11'd5, '0, 0);
        idleCycles(2, 11'd5);

        applyStimulus(0, 0, '0, '0, 0, 11'd5, '0, 1);
        applyStimulus(1, 0, 11'd5, '0, 0, 11'd5, '0, 0);
        applyStimulus(0, 1, 11'd5, 31'h0, 0, 11'd5, '0, 0);
        idleCycles(4, 11'd5);

        applyStimulus(0, 1, 11'd7, 31'h55, 0, 11'd7, '0, 0);
        applyStimulus(0, 0, '0, '0, 0, 11'd7, '0, 1);
        idleCycles(4, 11'd7);

        applyStimulus(1, 0, 11'd0, '0, 1, 11'd9, 31'h3, 0);
        idleCycles(5, 11'd9);
        applyStimulus(0, 0, '0, '0, 1, 11'd9, 31'h3, 0);
        idleCycles(2, 11'd9);

        for (int i = 0; i < 800; i++) begin
            r   = int'($urandom_range(0, 99));
            rp  = (r < 18) || (r >= 36 && r < 39);
            wp  = (r >= 18 && r < 39);
            dwe = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus(rp, wp, ADDR_W'($urandom_range(0, NADDR - 1)), DATA_W'($urandom),
                          dwe, ADDR_W'($urandom_range(0, NADDR - 1)), DATA_W'($urandom), rst);
        end
        idleCycles(6, '0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
